id_pipe: RTL and testbench
==========================

ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter XLEN, default 64, meaning: datapath width (legal values 32, 64).
REQ-002 Parameter CNT_W, default 32, meaning: stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid_i  input  1  upstream instruction valid.
REQ-006 in_ready_o  output  1  stage can accept an instruction this cycle.
REQ-007 inst_i  input  32  instruction word.
REQ-008 inst_addr_i  input  XLEN  instruction PC.
REQ-009 rs1_addr_o / rs2_addr_o  output  5  combinational register-file read addresses.
REQ-010 rs1_data_i / rs2_data_i  input  XLEN  register-file read data, same cycle.
REQ-011 ex_load_i  input  1  downstream stage holds a load.
REQ-012 ex_rd_i  input  5  destination of that load.
REQ-013 flush_i  input  1  kill held and incoming instruction.
REQ-014 out_valid_o  output  1  registered decode bundle valid.
REQ-015 out_ready_i  input  1  downstream accepts bundle.
REQ-016 Registered bundle outputs: inst_o 32, inst_addr_o XLEN, op1_o XLEN, op2_o XLEN, rd_addr_o 5, reg_wen_o 1, base_addr_o XLEN, offset_addr_o XLEN, mem_ren_o 1, mem_wen_o 1, illegal_o 1.
REQ-017 stall_cnt_o  output  CNT_W  hazard-stall cycle counter.

Function
REQ-018 Decode covers OP-IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; with XLEN=64 also OP-IMM-32, OP-32, LD/LWU/SD.
- Operands: OP-IMM op1=rs1, op2=sext immI; shifts op2=zero-ext shamt (6 bits XLEN=64, 5 bits XLEN=32).
- OP: op2=rs2, or zero-ext rs2[log2(XLEN)-1:0] for SLL/SRL/SRA.
- Branch: base=PC, offset=immB.
- JAL: op1=PC, op2=4, base=PC, offset=immJ; JALR: op1=PC, op2=4, base=rs1, offset=immI.
- Load: base=rs1, offset=immI, mem_ren=1; Store: base=rs1, offset=immS, op2=rs2, mem_wen=1.
- LUI op2=immU; AUIPC op1=PC, op2=immU.
- Immediates sign-extended to XLEN.
REQ-019 Unrecognised opcode/funct3/funct7, RV64-only encodings at XLEN=32, or shamt[5]=1 at XLEN=32 SHALL set illegal_o=1 with reg_wen_o=mem_ren_o=mem_wen_o=0.
REQ-020 rs1_addr_o/rs2_addr_o SHALL be 0 for formats not reading that source.
REQ-021 Hazard = ex_load_i && ex_rd_i!=0 && (ex_rd_i==rs1_addr_o || ex_rd_i==rs2_addr_o).
REQ-022 in_ready_o = !hazard && (!out_valid_o || out_ready_i).
REQ-023 Transfer when in_valid_i && in_ready_o: bundle registered, out_valid_o=1 next cycle (latency 1).
REQ-024 out_valid_o && out_ready_i with no new transfer: out_valid_o=0 next cycle.
REQ-025 Bundle SHALL stay stable while out_valid_o && !out_ready_i.
REQ-026 Simultaneous drain and transfer: new bundle loaded, out_valid_o stays 1 (full throughput).
REQ-027 flush_i: out_valid_o=0 next cycle, no transfer that cycle, regardless of other inputs.
REQ-028 stall_cnt_o increments each cycle in_valid_i && hazard && !flush_i; saturates at all-ones.

Reset
REQ-029 rst_n low SHALL immediately clear out_valid_o, all bundle outputs to 0, stall_cnt_o to 0; mid-transfer instruction discarded.
REQ-030 First transfer possible on first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ID_PIPE_MDU_EN defined: OP/OP-32 with funct7=0000001 (MUL..REMU, MULW..REMUW) decode as register-register ops, op2=rs2 unmasked.
REQ-032 Macro undefined: those encodings SHALL raise illegal_o=1.

Verification
REQ-033 ADDI x5,x1,-1, rs1=0x10 -> next cycle out_valid=1, op1=0x10, op2=0xFFFF_FFFF_FFFF_FFFF, rd=5, reg_wen=1.
REQ-034 ex_load=1, ex_rd=3, inst ADD x4,x3,x2 held 3 cycles -> in_ready=0, stall_cnt=3, then accepted when ex_load=0.
REQ-035 out_ready=0 for 4 cycles with new in_valid -> bundle unchanged, in_ready=0; out_ready=1 with in_valid -> back-to-back bundles.
REQ-036 XLEN=32, SLLI shamt=32 -> illegal_o=1, reg_wen=0; XLEN=64 same -> op2=32.
REQ-037 MUL x1,x2,x3 without ID_PIPE_MDU_EN -> illegal_o=1; with it -> op2=rs2, reg_wen=1.
REQ-038 flush_i during stall with out_valid=1 -> out_valid=0 next cycle; rst_n pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_pipe_if.sv
// id_pipe_if -- handshake and bundle signals of the instruction-decode stage.
// Signal directions are named from the decode stage's point of view.
//   slave  : used by id_pipe
//   master : used by whatever drives the stage (fetch side, regfile, EX side)
// Signals:
//   in_valid_i / in_ready_o          upstream instruction handshake
//   inst_i, inst_addr_i              instruction word and its PC
//   rs1_addr_o/rs2_addr_o            register-file read addresses (comb.)
//   rs1_data_i/rs2_data_i            register-file read data (same cycle)
//   ex_load_i, ex_rd_i               load in EX and its destination
//   flush_i                          kill held and incoming instruction
//   out_valid_o / out_ready_i        downstream bundle handshake
//   inst_o .. illegal_o              registered decode bundle
//   stall_cnt_o                      load-use stall cycle counter
interface id_pipe_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [XLEN-1:0]  inst_addr_i;
    logic [4:0]       rs1_addr_o;
    logic [4:0]       rs2_addr_o;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic             ex_load_i;
    logic [4:0]       ex_rd_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic [XLEN-1:0]  inst_addr_o;
    logic [XLEN-1:0]  op1_o;
    logic [XLEN-1:0]  op2_o;
    logic [4:0]       rd_addr_o;
    logic             reg_wen_o;
    logic [XLEN-1:0]  base_addr_o;
    logic [XLEN-1:0]  offset_addr_o;
    logic             mem_ren_o;
    logic             mem_wen_o;
    logic             illegal_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
               ex_load_i, ex_rd_i, flush_i, out_ready_i,
        output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
               inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
               base_addr_o, offset_addr_o, mem_ren_o, mem_wen_o, illegal_o,
               stall_cnt_o
    );

    modport master (
        output in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
               ex_load_i, ex_rd_i, flush_i, out_ready_i,
        input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
               inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
               base_addr_o, offset_addr_o, mem_ren_o, mem_wen_o, illegal_o,
               stall_cnt_o
    );
endinterface

// File: rtl/id_pipe.sv
// id_pipe -- RISC-V instruction decode stage with a one-entry output register.
// Decodes RV32I/RV64I integer instructions into an operand/address bundle,
// stalls on load-use hazards against the EX-stage load and counts stall cycles.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : id_pipe_if.slave (handshakes, regfile ports, decode bundle)
// Parameters: XLEN (32 or 64), CNT_W (stall counter width).
// Optional feature: define ID_PIPE_MDU_EN to accept the M-extension
// (funct7=0000001) encodings of OP/OP-32; otherwise they decode as illegal.
module id_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic      clk,
    input logic      rst_n,
    id_pipe_if.slave bus
);
    localparam bit RV64 = (XLEN == 64);
    localparam int SHW  = $clog2(XLEN);

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111
    } opcode_e;

    logic [31:0]     inst;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_f;
    logic [XLEN-1:0] rs1_data, rs2_data, pc;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
    logic            slli_ok, sri_ok, sriw_ok;

    assign inst     = bus.inst_i;
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign rd_f     = inst[11:7];
    assign rs1_data = bus.rs1_data_i;
    assign rs2_data = bus.rs2_data_i;
    assign pc       = bus.inst_addr_i;

    // Immediates are formed at 32 bits and then sign-extended to XLEN.
    assign imm_i = XLEN'($signed({{20{inst[31]}}, inst[31:20]}));
    assign imm_s = XLEN'($signed({{20{inst[31]}}, inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({{19{inst[31]}}, inst[31], inst[7],
                                  inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({{11{inst[31]}}, inst[31], inst[19:12],
                                  inst[20], inst[30:21], 1'b0}));

    // RV64 shifts use a 6-bit shamt; on RV32 shamt[5] (inst[25]) must be 0.
    assign shamt   = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    assign shamt_w = XLEN'(inst[24:20]);
    assign slli_ok = RV64 ? (inst[31:26] == 6'b000000) : (funct7 == 7'b0000000);
    assign sri_ok  = RV64 ? (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000)
                          : (funct7 == 7'b0000000 || funct7 == 7'b0100000);
    assign sriw_ok = (funct7 == 7'b0000000 || funct7 == 7'b0100000);

    logic            use_rs1, use_rs2, ill_d;
    logic            wen_d, ren_d, mwen_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] op1_d, op2_d, base_d, off_d;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        ill_d   = 1'b0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        mwen_d  = 1'b0;
        rd_d    = '0;
        op1_d   = '0;
        op2_d   = '0;
        base_d  = '0;
        off_d   = '0;
        case (inst[6:0])
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; wen_d = 1'b1; rd_d = rd_f;
                op1_d = rs1_data; op2_d = imm_i;
                case (funct3)
                    3'b001:  begin op2_d = shamt; ill_d = !slli_ok; end
                    3'b101:  begin op2_d = shamt; ill_d = !sri_ok;  end
                    default: ;
                endcase
            end
            OPC_OP_IMM_32: begin
                use_rs1 = 1'b1; wen_d = 1'b1; rd_d = rd_f;
                op1_d = rs1_data; op2_d = imm_i;
                case (funct3)
                    3'b000:  ;
                    3'b001:  begin op2_d = shamt_w; ill_d = (funct7 != 7'b0000000); end
                    3'b101:  begin op2_d = shamt_w; ill_d = !sriw_ok; end
                    default: ill_d = 1'b1;
                endcase
                if (!RV64) ill_d = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; wen_d = 1'b1; rd_d = rd_f;
                op1_d = rs1_data; op2_d = rs2_data;
                case (funct7)
                    7'b0000000: if (funct3 == 3'b001 || funct3 == 3'b101)
                                    op2_d = XLEN'(rs2_data[SHW-1:0]);
                    7'b0100000: begin
                        if (funct3 == 3'b101) op2_d = XLEN'(rs2_data[SHW-1:0]);
                        else if (funct3 != 3'b000) ill_d = 1'b1;
                    end
`ifdef ID_PIPE_MDU_EN
                    7'b0000001: ;
`endif
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; wen_d = 1'b1; rd_d = rd_f;
                op1_d = rs1_data; op2_d = rs2_data;
                case (funct7)
                    7'b0000000: begin
                        if (funct3 == 3'b001 || funct3 == 3'b101) op2_d = XLEN'(rs2_data[4:0]);
                        else if (funct3 != 3'b000) ill_d = 1'b1;
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b101) op2_d = XLEN'(rs2_data[4:0]);
                        else if (funct3 != 3'b000) ill_d = 1'b1;
                    end
`ifdef ID_PIPE_MDU_EN
                    7'b0000001: ill_d = (funct3 == 3'b001 || funct3 == 3'b010 ||
                                         funct3 == 3'b011);
`endif
                    default: ill_d = 1'b1;
                endcase
                if (!RV64) ill_d = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; wen_d = 1'b1; ren_d = 1'b1; rd_d = rd_f;
                base_d = rs1_data; off_d = imm_i;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
                    3'b011, 3'b110: ill_d = !RV64;
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; mwen_d = 1'b1;
                base_d = rs1_data; off_d = imm_s; op2_d = rs2_data;
                case (funct3)
                    3'b000, 3'b001, 3'b010: ;
                    3'b011:  ill_d = !RV64;
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                op1_d = rs1_data; op2_d = rs2_data; base_d = pc; off_d = imm_b;
                ill_d = (funct3 == 3'b010 || funct3 == 3'b011);
            end
            OPC_JAL: begin
                wen_d = 1'b1; rd_d = rd_f;
                op1_d = pc; op2_d = XLEN'(4); base_d = pc; off_d = imm_j;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; wen_d = 1'b1; rd_d = rd_f;
                op1_d = pc; op2_d = XLEN'(4); base_d = rs1_data; off_d = imm_i;
                ill_d = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                wen_d = 1'b1; rd_d = rd_f; op2_d = imm_u;
            end
            OPC_AUIPC: begin
                wen_d = 1'b1; rd_d = rd_f; op1_d = pc; op2_d = imm_u;
            end
            default: ill_d = 1'b1;
        endcase
        // An illegal instruction carries no side effects and reads no registers.
        if (ill_d) begin
            use_rs1 = 1'b0; use_rs2 = 1'b0;
            wen_d = 1'b0; ren_d = 1'b0; mwen_d = 1'b0;
            rd_d = '0; op1_d = '0; op2_d = '0; base_d = '0; off_d = '0;
        end
    end

    logic [4:0] rs1_addr, rs2_addr;
    logic       hazard, in_ready, xfer;
    logic       valid_q;

    assign rs1_addr = use_rs1 ? inst[19:15] : 5'd0;
    assign rs2_addr = use_rs2 ? inst[24:20] : 5'd0;
    assign hazard   = bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                      (bus.ex_rd_i == rs1_addr || bus.ex_rd_i == rs2_addr);
    assign in_ready = !hazard && (!valid_q || bus.out_ready_i);
    assign xfer     = bus.in_valid_i && in_ready && !bus.flush_i;

    logic [31:0]      inst_q;
    logic [XLEN-1:0]  pc_q, op1_q, op2_q, base_q, off_q;
    logic [4:0]       rd_q;
    logic             wen_q, ren_q, mwen_q, ill_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            inst_q      <= '0;
            pc_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            base_q      <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            mwen_q      <= 1'b0;
            ill_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (bus.flush_i)          valid_q <= 1'b0;
            else if (xfer)            valid_q <= 1'b1;
            else if (bus.out_ready_i) valid_q <= 1'b0;

            if (xfer) begin
                inst_q <= inst;
                pc_q   <= pc;
                op1_q  <= op1_d;
                op2_q  <= op2_d;
                base_q <= base_d;
                off_q  <= off_d;
                rd_q   <= rd_d;
                wen_q  <= wen_d;
                ren_q  <= ren_d;
                mwen_q <= mwen_d;
                ill_q  <= ill_d;
            end

            if (bus.in_valid_i && hazard && !bus.flush_i && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.rs1_addr_o    = rs1_addr;
    assign bus.rs2_addr_o    = rs2_addr;
    assign bus.out_valid_o   = valid_q;
    assign bus.inst_o        = inst_q;
    assign bus.inst_addr_o   = pc_q;
    assign bus.op1_o         = op1_q;
    assign bus.op2_o         = op2_q;
    assign bus.rd_addr_o     = rd_q;
    assign bus.reg_wen_o     = wen_q;
    assign bus.base_addr_o   = base_q;
    assign bus.offset_addr_o = off_q;
    assign bus.mem_ren_o     = ren_q;
    assign bus.mem_wen_o     = mwen_q;
    assign bus.illegal_o     = ill_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe -- self-checking bench for id_pipe.
// Main instance: XLEN=64, CNT_W=32, scoreboard-checked handshake and decode.
// Second instance: XLEN=32, CNT_W=2, RV32 legality and counter saturation.
module tb_id_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_pipe_if #(.XLEN(64), .CNT_W(32)) bus ();
    id_pipe_if #(.XLEN(32), .CNT_W(2))  bus32 ();

    id_pipe #(.XLEN(64), .CNT_W(32)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_pipe #(.XLEN(32), .CNT_W(2))  u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc, rs1d, rs2d;
        logic [4:0]  rs1a, rs2a, rd;
        logic [63:0] op1, op2, base, off;
        logic        wen, ren, mwen, ill;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    vec_t        sb[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] pc,
                                input logic [63:0] rs1d, input logic [63:0] rs2d,
                                input logic [4:0] rs1a, input logic [4:0] rs2a,
                                input logic [4:0] rd, input logic [63:0] op1,
                                input logic [63:0] op2, input logic [63:0] base,
                                input logic [63:0] off, input logic wen,
                                input logic ren, input logic mwen, input logic ill);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d;
        v.rs1a = rs1a; v.rs2a = rs2a; v.rd = rd;
        v.op1 = op1; v.op2 = op2; v.base = base; v.off = off;
        v.wen = wen; v.ren = ren; v.mwen = mwen; v.ill = ill;
        return v;
    endfunction

    task automatic check_bundle(input vec_t e);
        check_eq("inst_o",    64'(bus.inst_o),        64'(e.inst));
        check_eq("inst_addr", bus.inst_addr_o,        e.pc);
        check_eq("op1",       bus.op1_o,              e.op1);
        check_eq("op2",       bus.op2_o,              e.op2);
        check_eq("base",      bus.base_addr_o,        e.base);
        check_eq("offset",    bus.offset_addr_o,      e.off);
        check_eq("rd",        64'(bus.rd_addr_o),     64'(e.rd));
        check_eq("reg_wen",   64'(bus.reg_wen_o),     64'(e.wen));
        check_eq("mem_ren",   64'(bus.mem_ren_o),     64'(e.ren));
        check_eq("mem_wen",   64'(bus.mem_wen_o),     64'(e.mwen));
        check_eq("illegal",   64'(bus.illegal_o),     64'(e.ill));
    endtask

    // Called at a falling edge: drives one cycle of stimulus, checks the
    // combinational and held outputs against the model, then the state
    // after the next rising edge, and returns at the following falling edge.
    task automatic step(input vec_t s, input logic v, input logic ordy,
                        input logic exl, input logic [4:0] exrd, input logic fl);
        logic haz, rdy, xfer;
        bus.in_valid_i = v;      bus.inst_i = s.inst;    bus.inst_addr_i = s.pc;
        bus.rs1_data_i = s.rs1d; bus.rs2_data_i = s.rs2d;
        bus.ex_load_i = exl;     bus.ex_rd_i = exrd;     bus.flush_i = fl;
        bus.out_ready_i = ordy;
        #1;
        haz = exl && (exrd != 5'd0) && (exrd == s.rs1a || exrd == s.rs2a);
        rdy = !haz && (!m_valid || ordy);
        check_eq("in_ready",  64'(bus.in_ready_o),  64'(rdy));
        check_eq("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
        if (v) begin
            check_eq("rs1_addr", 64'(bus.rs1_addr_o), 64'(s.rs1a));
            check_eq("rs2_addr", 64'(bus.rs2_addr_o), 64'(s.rs2a));
        end
        if (m_valid && sb.size() != 0) begin
            check_bundle(sb[0]);
            if (ordy || fl) sb.delete(0);
        end
        xfer = v && rdy && !fl;
        if (v && haz && !fl && m_cnt != '1) m_cnt++;
        if (fl)        m_valid = 1'b0;
        else if (xfer) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        if (xfer) sb.push_back(s);
        @(posedge clk); #1;
        check_eq("out_valid_next", 64'(bus.out_valid_o), 64'(m_valid));
        check_eq("stall_cnt",      64'(bus.stall_cnt_o), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic run32(input string tag, input vec_t e);
        bus32.in_valid_i = 1'b1; bus32.inst_i = e.inst; bus32.inst_addr_i = e.pc[31:0];
        bus32.rs1_data_i = e.rs1d[31:0]; bus32.rs2_data_i = e.rs2d[31:0];
        bus32.out_ready_i = 1'b1; bus32.ex_load_i = 1'b0; bus32.flush_i = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 64'(bus32.out_valid_o), 64'd1);
        check_eq({tag, "_op1"},   64'(bus32.op1_o),       e.op1);
        check_eq({tag, "_op2"},   64'(bus32.op2_o),       e.op2);
        check_eq({tag, "_wen"},   64'(bus32.reg_wen_o),   64'(e.wen));
        check_eq({tag, "_ren"},   64'(bus32.mem_ren_o),   64'(e.ren));
        check_eq({tag, "_ill"},   64'(bus32.illegal_o),   64'(e.ill));
        @(negedge clk);
        bus32.in_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "tb_id_pipe timeout");
    end

    initial begin
        vec_t v_addi, v_add, v_slli, v_sw, v_ld, v_beq, v_jal, v_jalr, v_lui, v_auipc;
        vec_t v_mul, v_bad, v32_addi, v32_slli32, v32_slli31, v32_ld, v32_lui;
        logic [63:0] sat_exp;

        v_addi  = mk(32'hFFF08293, 64'h1000, 64'h10, 64'h0, 5'd1, 5'd0, 5'd5,
                     64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 0, 0, 0);
        v_add   = mk(32'h00218233, 64'h1004, 64'h1111, 64'h2222, 5'd3, 5'd2, 5'd4,
                     64'h1111, 64'h2222, 64'h0, 64'h0, 1, 0, 0, 0);
        v_slli  = mk(32'h02039313, 64'h1008, 64'hABCD, 64'h0, 5'd7, 5'd0, 5'd6,
                     64'hABCD, 64'd32, 64'h0, 64'h0, 1, 0, 0, 0);
        v_sw    = mk(32'h00532423, 64'h100C, 64'h2000, 64'h5555, 5'd6, 5'd5, 5'd0,
                     64'h0, 64'h5555, 64'h2000, 64'd8, 0, 0, 1, 0);
        v_ld    = mk(32'hFF013503, 64'h1010, 64'h3000, 64'h0, 5'd2, 5'd0, 5'd10,
                     64'h0, 64'h0, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 0, 0);
        v_beq   = mk(32'hFE208CE3, 64'h1014, 64'h7, 64'h9, 5'd1, 5'd2, 5'd0,
                     64'h7, 64'h9, 64'h1014, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0);
        v_jal   = mk(32'h010000EF, 64'h1018, 64'h0, 64'h0, 5'd0, 5'd0, 5'd1,
                     64'h1018, 64'd4, 64'h1018, 64'd16, 1, 0, 0, 0);
        v_jalr  = mk(32'h00C280E7, 64'h102C, 64'h4000, 64'h0, 5'd5, 5'd0, 5'd1,
                     64'h102C, 64'd4, 64'h4000, 64'd12, 1, 0, 0, 0);
        v_lui   = mk(32'h800003B7, 64'h101C, 64'h0, 64'h0, 5'd0, 5'd0, 5'd7,
                     64'h0, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0, 1, 0, 0, 0);
        v_auipc = mk(32'h00001417, 64'h1020, 64'h0, 64'h0, 5'd0, 5'd0, 5'd8,
                     64'h1020, 64'h1000, 64'h0, 64'h0, 1, 0, 0, 0);
`ifdef ID_PIPE_MDU_EN
        v_mul   = mk(32'h023100B3, 64'h1024, 64'h6, 64'h7, 5'd2, 5'd3, 5'd1,
                     64'h6, 64'h7, 64'h0, 64'h0, 1, 0, 0, 0);
`else
        v_mul   = mk(32'h023100B3, 64'h1024, 64'h6, 64'h7, 5'd0, 5'd0, 5'd0,
                     64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 1);
`endif
        v_bad   = mk(32'h0000007F, 64'h1028, 64'h1, 64'h2, 5'd0, 5'd0, 5'd0,
                     64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 1);

        v32_addi   = mk(32'hFFF08293, 64'h0, 64'h10, 64'h0, 5'd1, 5'd0, 5'd5,
                        64'h10, 64'hFFFF_FFFF, 64'h0, 64'h0, 1, 0, 0, 0);
        v32_slli32 = mk(32'h02039313, 64'h0, 64'hABCD, 64'h0, 5'd0, 5'd0, 5'd0,
                        64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 1);
        v32_slli31 = mk(32'h01F39313, 64'h0, 64'hABCD, 64'h0, 5'd7, 5'd0, 5'd6,
                        64'hABCD, 64'd31, 64'h0, 64'h0, 1, 0, 0, 0);
        v32_ld     = mk(32'hFF013503, 64'h0, 64'h3000, 64'h0, 5'd0, 5'd0, 5'd0,
                        64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 1);
        v32_lui    = mk(32'h800003B7, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd7,
                        64'h0, 64'h8000_0000, 64'h0, 64'h0, 1, 0, 0, 0);

        // Reset with an instruction offered: nothing may be captured.
        bus.in_valid_i = 1'b1; bus.inst_i = v_addi.inst; bus.inst_addr_i = v_addi.pc;
        bus.rs1_data_i = v_addi.rs1d; bus.rs2_data_i = '0; bus.ex_load_i = 1'b0;
        bus.ex_rd_i = '0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
        bus32.in_valid_i = 1'b0; bus32.inst_i = '0; bus32.inst_addr_i = '0;
        bus32.rs1_data_i = '0; bus32.rs2_data_i = '0; bus32.ex_load_i = 1'b0;
        bus32.ex_rd_i = '0; bus32.flush_i = 1'b0; bus32.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_op1",       bus.op1_o,             64'd0);
        check_eq("rst_inst",      64'(bus.inst_o),       64'd0);
        check_eq("rst_stall",     64'(bus.stall_cnt_o),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back decode of every format; first transfer on the first edge.
        step(v_addi, 1, 1, 0, 5'd0, 0);
        step(v_add,  1, 1, 0, 5'd0, 0);
        step(v_slli, 1, 1, 0, 5'd0, 0);
        step(v_sw,   1, 1, 0, 5'd0, 0);
        step(v_ld,   1, 1, 0, 5'd0, 0);
        step(v_beq,  1, 1, 0, 5'd0, 0);
        step(v_jal,  1, 1, 0, 5'd0, 0);
        step(v_jalr, 1, 1, 0, 5'd0, 0);
        step(v_lui,  1, 1, 0, 5'd0, 0);
        step(v_auipc,1, 1, 0, 5'd0, 0);
        step(v_mul,  1, 1, 0, 5'd0, 0);
        step(v_bad,  1, 1, 0, 5'd0, 0);
        step(v_addi, 0, 1, 0, 5'd0, 0);

        // Load-use hazard on rs1 for three cycles, then released.
        for (int unsigned i = 0; i < 3; i++) step(v_add, 1, 1, 1, 5'd3, 0);
        step(v_add, 1, 1, 0, 5'd3, 0);
        step(v_add, 1, 1, 1, 5'd2, 0);   // hazard through rs2
        step(v_add, 1, 1, 0, 5'd0, 0);
        step(v_add, 1, 1, 1, 5'd0, 0);   // x0 never hazards
        step(v_lui, 1, 1, 1, 5'd7, 0);   // LUI reads no sources
        step(v_addi, 0, 1, 0, 5'd0, 0);

        // Backpressure: bundle held for four cycles, then drain+load, then stream.
        step(v_addi, 1, 0, 0, 5'd0, 0);
        for (int unsigned i = 0; i < 4; i++) step(v_add, 1, 0, 0, 5'd0, 0);
        step(v_add, 1, 1, 0, 5'd0, 0);
        step(v_sw,  1, 1, 0, 5'd0, 0);
        step(v_ld,  1, 1, 0, 5'd0, 0);
        step(v_addi, 0, 1, 0, 5'd0, 0);

        // Flush while stalled with a held bundle, then flush with valid input.
        step(v_addi, 1, 0, 0, 5'd0, 0);
        step(v_add,  1, 0, 1, 5'd3, 0);
        step(v_add,  1, 0, 1, 5'd3, 1);
        step(v_add,  1, 1, 0, 5'd0, 1);
        step(v_addi, 0, 1, 0, 5'd0, 0);

        // Asynchronous reset in mid-stream with a held bundle.
        step(v_beq, 1, 0, 0, 5'd0, 0);
        #2;
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("arst_op1",       bus.op1_o,             64'd0);
        check_eq("arst_base",      bus.base_addr_o,       64'd0);
        check_eq("arst_inst",      64'(bus.inst_o),       64'd0);
        check_eq("arst_stall",     64'(bus.stall_cnt_o),  64'd0);
        m_valid = 1'b0; m_cnt = '0; sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(v_jal,  1, 1, 0, 5'd0, 0);
        step(v_addi, 0, 1, 0, 5'd0, 0);

        // XLEN=32 instance: RV32 legality rules and sign extension.
        run32("rv32_addi",    v32_addi);
        run32("rv32_slli32",  v32_slli32);
        run32("rv32_slli31",  v32_slli31);
        run32("rv32_ld",      v32_ld);
        run32("rv32_lui",     v32_lui);

        // 2-bit stall counter saturates at all-ones.
        bus32.inst_i = v_add.inst; bus32.in_valid_i = 1'b1;
        bus32.ex_load_i = 1'b1; bus32.ex_rd_i = 5'd3;
        for (int unsigned k = 1; k <= 5; k++) begin
            #1;
            check_eq("sat_in_ready", 64'(bus32.in_ready_o), 64'd0);
            @(posedge clk); #1;
            sat_exp = (k > 3) ? 64'd3 : 64'(k);
            check_eq("sat_cnt", 64'(bus32.stall_cnt_o), sat_exp);
            @(negedge clk);
        end
        bus32.in_valid_i = 1'b0; bus32.ex_load_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
